// File: rtl/div_if.sv
// Handshake, result and external-subtractor signals of the sequenced divider.
interface div_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic             div_zero;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic [WIDTH-1:0] sub_a;
   logic [WIDTH-1:0] sub_b;
   logic [WIDTH:0]   sub_r;

   // Requester side, which also hosts the shared subtractor.
   modport master (
      output start, dividend, divisor, sub_r,
      input  busy, done, div_zero, quotient, remainder, sub_a, sub_b
   );

   // Divider sequencer side.
   modport slave (
      input  start, dividend, divisor, sub_r,
      output busy, done, div_zero, quotient, remainder, sub_a, sub_b
   );
endinterface

// File: rtl/div_sequencer.sv
// Restoring unsigned divider sequencer: one quotient bit per clock using an
// external shared WIDTH-bit subtractor.
module div_sequencer #(
   parameter int unsigned WIDTH = 32
) (
   input logic  clk,
   input logic  rst_n,
   div_if.slave bus
);
   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] div_q, div_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             div_zero_q, div_zero_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;

   logic [WIDTH:0]   shifted_c;
   logic             ge_c;
   logic [WIDTH-1:0] iter_rem_c;
   logic [WIDTH-1:0] iter_quo_c;
   logic [WIDTH-1:0] sub_a_c;
   logic [WIDTH-1:0] sub_b_c;

   // One restoring step; a set bit shifted out of rem always means rem >= divisor.
   always_comb begin
      shifted_c  = {rem_q, quo_q[WIDTH-1]};
      ge_c       = shifted_c[WIDTH] | bus.sub_r[WIDTH];
      iter_rem_c = ge_c ? bus.sub_r[WIDTH-1:0] : shifted_c[WIDTH-1:0];
      iter_quo_c = {quo_q[WIDTH-2:0], ge_c};
      sub_a_c    = '0;
      sub_b_c    = '0;
      if (state_q == S_RUN) begin
         sub_a_c = shifted_c[WIDTH-1:0];
         sub_b_c = div_q;
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      div_d       = div_q;
      cnt_d       = cnt_q;
      div_zero_d  = div_zero_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (state_q == S_DONE) begin
               state_d = S_IDLE;
            end
            if (bus.start) begin
               if (bus.divisor != '0) begin
                  rem_d      = '0;
                  quo_d      = bus.dividend;
                  div_d      = bus.divisor;
                  cnt_d      = '0;
                  div_zero_d = 1'b0;
                  state_d    = S_RUN;
               end else begin
                  quotient_d  = '1;
                  remainder_d = bus.dividend;
                  div_zero_d  = 1'b1;
                  state_d     = S_DONE;
               end
            end
         end
         S_RUN: begin
            rem_d = iter_rem_c;
            quo_d = iter_quo_c;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               cnt_d       = cnt_q;
               quotient_d  = iter_quo_c;
               remainder_d = iter_rem_c;
               state_d     = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

   // State and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         rem_q       <= '0;
         quo_q       <= '0;
         div_q       <= '0;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         div_zero_q  <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         div_q       <= div_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         div_zero_q  <= div_zero_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.div_zero  = div_zero_q;
   assign bus.quotient  = quotient_q;
   assign bus.remainder = remainder_q;
   assign bus.sub_a     = sub_a_c;
   assign bus.sub_b     = sub_b_c;
endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer with a behavioural external subtractor.
module tb_div_sequencer;
   typedef struct packed {
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
   } exp_t;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;
   exp_t sb[$];

   div_if #(.WIDTH(32)) bus ();

   div_sequencer #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // External subtractor: difference plus carry (1 when a >= b).
   assign bus.sub_r = {1'b0, bus.sub_a} + {1'b0, ~bus.sub_b} + 33'd1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
      end
   endtask

   // Monitor: pop and compare on every done; also guard subtractor operands.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("quotient", bus.quotient, e.q);
               check("remainder", bus.remainder, e.r);
               check("div_zero", 32'(bus.div_zero), 32'(e.dz));
            end
         end
         if (bus.busy !== 1'b1) begin
            check("sub_a_idle", bus.sub_a, 32'd0);
            check("sub_b_idle", bus.sub_b, 32'd0);
         end else begin
            tests++;
            if (bus.sub_b == 32'd0) begin
               fails++;
               $display("FAIL sub_b_run: got 0x%h expected nonzero", bus.sub_b);
            end
         end
      end
   end

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] eq,
                        input logic [31:0] er, input logic edz, input bit push);
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      if (push) sb.push_back('{q: eq, r: er, dz: edz});
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int n);
      n = 0;
      for (int k = 1; k <= limit; k++) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) begin
            n = k;
            return;
         end
      end
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done in %0d edges expected done", limit);
   endtask

   logic [31:0] tv_a [9] = '{32'd100, 32'hFFFF_FFFF, 32'h8000_0000, 32'd5, 32'd3,
                             32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1000};
   logic [31:0] tv_b [9] = '{32'd7, 32'd1, 32'hFFFF_FFFF, 32'd5, 32'd10,
                             32'd9, 32'hFFFF_FFFF, 32'd2, 32'd3};
   logic [31:0] tv_q [9] = '{32'd14, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd0,
                             32'd0, 32'd1, 32'h7FFF_FFFF, 32'd333};
   logic [31:0] tv_r [9] = '{32'd2, 32'd0, 32'h8000_0000, 32'd0, 32'd3,
                             32'd0, 32'd0, 32'd1, 32'd1};

   initial begin
      int n;
      int busy_cnt;
      int done_at;
      int done_cnt;
      logic [31:0] a;
      logic [31:0] b;
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;

      // Reset values.
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_div_zero", 32'(bus.div_zero), 32'd0);
      check("rst_quotient", bus.quotient, 32'd0);
      check("rst_remainder", bus.remainder, 32'd0);
      check("rst_sub_a", bus.sub_a, 32'd0);
      check("rst_sub_b", bus.sub_b, 32'd0);
      rst_n = 1'b1;

      // 100/7 with cycle-exact busy/done timing.
      issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
      check("e0_busy", 32'(bus.busy), 32'd1);
      busy_cnt = 1;
      done_at  = 0;
      done_cnt = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (bus.busy === 1'b1) busy_cnt++;
         if (bus.done === 1'b1) begin
            done_cnt++;
            if (done_at == 0) done_at = k;
         end
      end
      check("done_edge", 32'(done_at), 32'd32);
      check("busy_cycles", 32'(busy_cnt), 32'd32);
      check("done_pulses", 32'(done_cnt), 32'd1);

      // Hand-computed vectors, including forced-ge cases.
      for (int i = 1; i < 9; i++) begin
         issue(tv_a[i], tv_b[i], tv_q[i], tv_r[i], 1'b0, 1'b1);
         wait_done(40, n);
         check("latency", 32'(n), 32'd32);
      end

      // Divide by zero: immediate done, busy never asserts.
      issue(32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b1);
      check("dz_done", 32'(bus.done), 32'd1);
      check("dz_flag", 32'(bus.div_zero), 32'd1);
      check("dz_busy", 32'(bus.busy), 32'd0);
      @(posedge clk);
      #1;
      check("dz_done_clear", 32'(bus.done), 32'd0);

      // Ignored start in RUN, then start accepted in the DONE cycle.
      issue(32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 1'b1);
      repeat (9) @(posedge clk);
      #1;
      bus.start    = 1'b1;
      bus.dividend = 32'd9;
      bus.divisor  = 32'd3;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done(40, n);
      check("ignored_start_lat", 32'(n), 32'd22);
      bus.start    = 1'b1;
      bus.dividend = 32'd9;
      bus.divisor  = 32'd3;
      sb.push_back('{q: 32'd3, r: 32'd0, dz: 1'b0});
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check("b2b_busy", 32'(bus.busy), 32'd1);
      check("b2b_done_low", 32'(bus.done), 32'd0);
      wait_done(40, n);
      check("b2b_lat", 32'(n), 32'd32);

      // Asynchronous reset mid-RUN loses the operation.
      issue(32'd1000, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0);
      repeat (14) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_busy", 32'(bus.busy), 32'd0);
      check("arst_done", 32'(bus.done), 32'd0);
      check("arst_quotient", bus.quotient, 32'd0);
      check("arst_remainder", bus.remainder, 32'd0);
      check("arst_sub_a", bus.sub_a, 32'd0);
      check("arst_sub_b", bus.sub_b, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      issue(32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 1'b1);
      wait_done(40, n);

      // Random pairs with divisor=1, divisor=dividend and divisor>dividend mixed in.
      for (int i = 0; i < 200; i++) begin
         a = $urandom;
         case (i % 5)
            0:       b = 32'd1;
            1:       b = a;
            2:       b = a + 32'd1 + 32'($urandom_range(0, 100));
            default: b = $urandom >> (i % 32);
         endcase
         if (b == 32'd0) begin
            issue(a, b, 32'hFFFF_FFFF, a, 1'b1, 1'b1);
         end else begin
            issue(a, b, a / b, a % b, 1'b0, 1'b1);
            wait_done(40, n);
         end
      end

      repeat (3) @(negedge clk);
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global bound in case the sequence itself stalls.
   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule
